// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Captures the decoded instruction from ID and presents it to EX. A load
// in EX whose destination is read by the ID instruction inserts one bubble
// and freezes PC and IF/ID for that cycle. Inserted bubbles are counted
// in a saturating counter that only reset clears.
module id_ex_stage #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CTRL_WIDTH  = 9,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CTRL_WIDTH-1:0]  id_Ctrl,
  input  logic [DATA_WIDTH-1:0]  id_ReadData1,
  input  logic [DATA_WIDTH-1:0]  id_ReadData2,
  input  logic [DATA_WIDTH-1:0]  id_Immediate,
  input  logic [DATA_WIDTH-1:0]  id_PC4,
  input  logic [4:0]             id_Rs,
  input  logic [4:0]             id_Rt,
  input  logic [4:0]             id_Rd,
  input  logic                   flush,
  input  logic                   hold,
  output logic [CTRL_WIDTH-1:0]  ex_Ctrl,
  output logic [DATA_WIDTH-1:0]  ex_ReadData1,
  output logic [DATA_WIDTH-1:0]  ex_ReadData2,
  output logic [DATA_WIDTH-1:0]  ex_Immediate,
  output logic [DATA_WIDTH-1:0]  ex_PC4,
  output logic [4:0]             ex_Rs,
  output logic [4:0]             ex_Rt,
  output logic [4:0]             ex_Rd,
  output logic                   PCWrite,
  output logic                   IFID_Write,
  output logic [COUNT_WIDTH-1:0] BubbleCount
);

  // Bit position of MemRead inside the control bundle.
  localparam int unsigned MEMREAD_BIT = 6;

  logic [CTRL_WIDTH-1:0]  ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]  rd1_q,  rd1_d;
  logic [DATA_WIDTH-1:0]  rd2_q,  rd2_d;
  logic [DATA_WIDTH-1:0]  imm_q,  imm_d;
  logic [DATA_WIDTH-1:0]  pc4_q,  pc4_d;
  logic [4:0]             rs_q,   rs_d;
  logic [4:0]             rt_q,   rt_d;
  logic [4:0]             rd_q,   rd_d;
  logic [COUNT_WIDTH-1:0] cnt_q,  cnt_d;

  logic hazard;
  logic stall;

  // Load in EX whose nonzero destination is a source of the ID instruction.
  always_comb begin
    hazard = ctrl_q[MEMREAD_BIT] && (rt_q != 5'd0) &&
             ((rt_q == id_Rs) || (rt_q == id_Rt));
  end

  // Freeze PC and IF/ID on hold, or on a hazard that a flush does not override.
  always_comb begin
    stall      = hold || (hazard && !flush);
    PCWrite    = !stall;
    IFID_Write = !stall;
  end

  // Next-state selection: hold > flush > hazard bubble > normal load.
  always_comb begin
    ctrl_d = ctrl_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    pc4_d  = pc4_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (hold) begin
      // keep everything
    end else if (flush || hazard) begin
      // A bubble is all-zero, so its Rt can never match and retrigger a stall.
      ctrl_d = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      pc4_d  = '0;
      rs_d   = '0;
      rt_d   = '0;
      rd_d   = '0;
      if (!flush && (cnt_q != '1)) begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end
    end else begin
      ctrl_d = id_Ctrl;
      rd1_d  = id_ReadData1;
      rd2_d  = id_ReadData2;
      imm_d  = id_Immediate;
      pc4_d  = id_PC4;
      rs_d   = id_Rs;
      rt_d   = id_Rt;
      rd_d   = id_Rd;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc4_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc4_q  <= pc4_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ex_Ctrl      = ctrl_q;
  assign ex_ReadData1 = rd1_q;
  assign ex_ReadData2 = rd2_q;
  assign ex_Immediate = imm_q;
  assign ex_PC4       = pc4_q;
  assign ex_Rs        = rs_q;
  assign ex_Rt        = rt_q;
  assign ex_Rd        = rd_q;
  assign BubbleCount  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes expected per-cycle
// results from a behavioural model, monitor pops and compares.
module tb_id_ex_stage;

  localparam int CW     = 2;
  localparam int CNTMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } instr_t;

  typedef struct {
    logic   run_ok;   // expected PCWrite/IFID_Write before the edge
    instr_t ex;       // expected EX fields after the edge
    int     cnt;      // expected BubbleCount after the edge
  } exp_t;

  logic clk = 0;
  logic reset, flush, hold;
  logic [8:0]  id_Ctrl;
  logic [31:0] id_ReadData1, id_ReadData2, id_Immediate, id_PC4;
  logic [4:0]  id_Rs, id_Rt, id_Rd;
  logic [8:0]  ex_Ctrl;
  logic [31:0] ex_ReadData1, ex_ReadData2, ex_Immediate, ex_PC4;
  logic [4:0]  ex_Rs, ex_Rt, ex_Rd;
  logic PCWrite, IFID_Write;
  logic [CW-1:0] BubbleCount;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(32), .CTRL_WIDTH(9), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .id_Ctrl(id_Ctrl), .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2),
    .id_Immediate(id_Immediate), .id_PC4(id_PC4),
    .id_Rs(id_Rs), .id_Rt(id_Rt), .id_Rd(id_Rd),
    .flush(flush), .hold(hold),
    .ex_Ctrl(ex_Ctrl), .ex_ReadData1(ex_ReadData1), .ex_ReadData2(ex_ReadData2),
    .ex_Immediate(ex_Immediate), .ex_PC4(ex_PC4),
    .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .ex_Rd(ex_Rd),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .BubbleCount(BubbleCount)
  );

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;

  // Reference model: what currently sits in EX, and bubbles counted so far.
  instr_t m_ex  = '0;
  int     m_cnt = 0;

  task automatic step(input logic rst_n, input logic hd, input logic fl, input instr_t id);
    exp_t e;
    bit   is_load_use;
    @(negedge clk);
    reset = rst_n; hold = hd; flush = fl;
    id_Ctrl = id.ctrl; id_ReadData1 = id.rd1; id_ReadData2 = id.rd2;
    id_Immediate = id.imm; id_PC4 = id.pc4;
    id_Rs = id.rs; id_Rt = id.rt; id_Rd = id.rd;
    // A load in EX writing a real register that the ID instruction reads.
    is_load_use = m_ex.ctrl[6] && m_ex.rt != 0 && (m_ex.rt == id.rs || m_ex.rt == id.rt);
    e.run_ok = !(hd || (is_load_use && !fl));
    if (!rst_n) begin
      m_ex = '0; m_cnt = 0;
    end else if (!hd) begin
      if (fl) m_ex = '0;
      else if (is_load_use) begin
        m_ex = '0;
        m_cnt = (m_cnt == CNTMAX) ? CNTMAX : m_cnt + 1;
      end else m_ex = id;
    end
    e.ex  = m_ex;
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  function automatic instr_t mk(input logic [8:0] c, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] d1);
    instr_t i;
    i.ctrl = c; i.rs = rs; i.rt = rt; i.rd = rd; i.rd1 = d1;
    i.rd2 = $urandom; i.imm = $urandom; i.pc4 = $urandom;
    return i;
  endfunction

  // Monitor: stall outputs just before the edge, registers just after.
  initial begin
    exp_t   e;
    instr_t got;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (PCWrite !== e.run_ok || IFID_Write !== e.run_ok) begin
          errors++;
          $display("FAIL stall t=%0t PCWrite=%b IFID_Write=%b expected=%b",
                   $time, PCWrite, IFID_Write, e.run_ok);
        end
        @(posedge clk);
        #1;
        got = {ex_Ctrl, ex_ReadData1, ex_ReadData2, ex_Immediate, ex_PC4, ex_Rs, ex_Rt, ex_Rd};
        checks++;
        if (got !== e.ex) begin
          errors++;
          $display("FAIL ex_regs t=%0t got=%h expected=%h", $time, got, e.ex);
        end
        checks++;
        if (int'(BubbleCount) != e.cnt) begin
          errors++;
          $display("FAIL bubble_count t=%0t got=%0d expected=%0d", $time, BubbleCount, e.cnt);
        end
      end
    end
  end

  initial begin
    instr_t lw8, use8, z;
    int     wait_cycles;
    z = '0;
    reset = 0; hold = 0; flush = 0;
    {id_Ctrl, id_ReadData1, id_ReadData2, id_Immediate, id_PC4, id_Rs, id_Rt, id_Rd} = '0;
    repeat (2) @(posedge clk);

    // Reset state.
    step(0, 0, 0, mk(9'h1FF, 5'd7, 5'd7, 5'd7, 32'hDEAD));
    // Pass-through.
    step(1, 0, 0, mk(9'h188, 5'd3, 5'd4, 5'd5, 32'h11));
    // Load-use: lw $8 then a consumer of $8, then the held instruction enters.
    lw8  = mk(9'h1D0, 5'd2, 5'd8, 5'd0, 32'h22);
    use8 = mk(9'h188, 5'd8, 5'd9, 5'd10, 32'h33);
    step(1, 0, 0, lw8);
    step(1, 0, 0, use8);
    step(1, 0, 0, use8);
    // Zero register: load into $0 followed by a reader of $0.
    step(1, 0, 0, mk(9'h1D0, 5'd1, 5'd0, 5'd0, 32'h44));
    step(1, 0, 0, mk(9'h188, 5'd0, 5'd0, 5'd6, 32'h55));
    // Flush in the same cycle as a load-use hazard.
    step(1, 0, 0, lw8);
    step(1, 0, 1, use8);
    // Hold for 3 cycles with changing inputs and flush asserted.
    step(1, 0, 0, lw8);
    for (int i = 0; i < 3; i++) step(1, 1, 1, mk(9'(i + 1), 5'd8, 5'd8, 5'(i), $urandom));
    // Saturation: a repeated self-dependent load bubbles every other cycle.
    step(0, 0, 0, z);
    lw8.rs = 5'd8;
    for (int i = 0; i < 11; i++) step(1, 0, 0, lw8);
    // Reset asserted mid-stall.
    step(1, 0, 0, lw8);
    step(0, 0, 0, use8);
    step(1, 0, 0, use8);

    // Randomized traffic with a small register pool to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      instr_t r;
      r = mk(9'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom), $urandom);
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), r);
    end

    wait_cycles = 0;
    while (q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
